// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: watches a one-hot ring counter. Each enabled clock it checks that
// the sample is one-hot and is exactly one rotation past the previous enabled sample.
// It reports the hot-bit index, lock status and completed revolutions. A sticky error
// records the first fault cause.
module ring_phase_monitor #(
  parameter int WIDTH      = 4,
  parameter int REV_W      = 8,
  parameter int LOCK_STEPS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         ring_q,
  input  logic                     clr,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     phase_vld,
  output logic                     locked,
  output logic                     rev_tick,
  output logic [REV_W-1:0]         rev_cnt,
  output logic                     err,
  output logic [1:0]               err_code
);

  localparam int PH_W  = $clog2(WIDTH);
  localparam int CNT_W = (LOCK_STEPS < 1) ? 1 : $clog2(LOCK_STEPS + 1);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic               phase_vld_q, phase_vld_d;
  logic               rev_tick_q, rev_tick_d;
  logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;

  logic [WIDTH-1:0]   prev_rot;
  logic               is_onehot;
  logic               legal_step;
  logic               wrap_step;
  logic [PH_W-1:0]    hot_idx;
  logic               fault;
  logic [1:0]         fault_code;

  // Expected next sample: previous sample rotated left by one (bit i -> bit i+1 mod WIDTH).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
    assign prev_rot[(gi + 1) % WIDTH] = prev_q[gi];
  end

  // Decode the current sample: one-hot test, hot-bit index and step legality.
  always_comb begin
    is_onehot = (ring_q != '0) && ((ring_q & (ring_q - WIDTH'(1))) == '0);
    hot_idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_q[i]) hot_idx = PH_W'(i);
    end
    legal_step = is_onehot && (ring_q == prev_rot);
    wrap_step  = legal_step && prev_q[WIDTH-1];
  end

  // Tracking FSM, phase/revolution bookkeeping and sticky error next-state logic.
  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    prev_d      = prev_q;
    phase_d     = phase_q;
    phase_vld_d = phase_vld_q;
    rev_tick_d  = 1'b0;
    rev_cnt_d   = rev_cnt_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    fault       = 1'b0;
    fault_code  = 2'b00;

    if (en) begin
      prev_d      = ring_q;
      phase_vld_d = is_onehot;
      if (is_onehot) phase_d = hot_idx;

      case (state_q)
        S_SYNC: begin
          if (is_onehot) begin
            state_d    = S_ACQ;
            step_cnt_d = '0;
          end
        end
        S_ACQ: begin
          if (legal_step) begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
            if (step_cnt_d == CNT_W'(LOCK_STEPS)) state_d = S_LOCKED;
          end else begin
            state_d = S_SYNC;
          end
        end
        S_LOCKED: begin
          if (legal_step) begin
            if (wrap_step) begin
              rev_tick_d = 1'b1;
              rev_cnt_d  = rev_cnt_q + REV_W'(1);
            end
          end else begin
            state_d    = S_FAULT;
            fault      = 1'b1;
            fault_code = is_onehot ? 2'b10 : 2'b01;
          end
        end
        S_FAULT: state_d = S_SYNC;
        default: state_d = S_SYNC;
      endcase
    end

    // clr wipes the counters first so a fault in the same cycle still lands.
    if (clr) begin
      rev_cnt_d  = '0;
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end
    if (fault) begin
      err_d = 1'b1;
      if (!err_q || clr) err_code_d = fault_code;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_SYNC;
      step_cnt_q  <= '0;
      prev_q      <= '0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      rev_tick_q  <= 1'b0;
      rev_cnt_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      prev_q      <= prev_d;
      phase_q     <= phase_d;
      phase_vld_q <= phase_vld_d;
      rev_tick_q  <= rev_tick_d;
      rev_cnt_q   <= rev_cnt_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign phase     = phase_q;
  assign phase_vld = phase_vld_q;
  assign locked    = (state_q == S_LOCKED);
  assign rev_tick  = rev_tick_q;
  assign rev_cnt   = rev_cnt_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Testbench for ring_phase_monitor: directed ring sequences, a run-length model of the
// lock/revolution/error rules compared every cycle, plus hand-computed literal checks.
module tb_ring_phase_monitor;

  localparam int W    = 4;
  localparam int LOCK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [3:0] ring;

  logic [1:0] phase, phase2;
  logic       phase_vld, phase_vld2;
  logic       locked, locked2;
  logic       rev_tick, rev_tick2;
  logic [7:0] rev_cnt;
  logic [1:0] rev_cnt2;
  logic       err, err2;
  logic [1:0] err_code, err_code2;

  ring_phase_monitor #(.WIDTH(4), .REV_W(8), .LOCK_STEPS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .ring_q(ring), .clr(clr),
    .phase(phase), .phase_vld(phase_vld), .locked(locked), .rev_tick(rev_tick),
    .rev_cnt(rev_cnt), .err(err), .err_code(err_code)
  );

  ring_phase_monitor #(.WIDTH(4), .REV_W(2), .LOCK_STEPS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .ring_q(ring), .clr(clr),
    .phase(phase2), .phase_vld(phase_vld2), .locked(locked2), .rev_tick(rev_tick2),
    .rev_cnt(rev_cnt2), .err(err2), .err_code(err_code2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  // Model: run = -1 when no anchor sample, else number of consecutive legal steps since
  // the anchor; locked once run reaches LOCK. After a fault the next sample is discarded.
  int  m_run;
  bit  m_skip;
  int  m_prev;
  int  m_phase;
  bit  m_vld;
  bit  m_tick;
  int  m_rev;
  bit  m_err;
  int  m_code;
  logic [3:0] cur;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hot_of(input logic [3:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) begin
        cnt++;
        idx = i;
      end
    end
    return (cnt == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    m_run = -1; m_skip = 0; m_prev = 0; m_phase = 0; m_vld = 0;
    m_tick = 0; m_rev = 0; m_err = 0; m_code = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic e, input logic c);
    int hp, hr, fcode;
    bit legal, wrap;
    fcode  = 0;
    m_tick = 0;
    if (e) begin
      hr    = hot_of(r);
      hp    = hot_of(4'(m_prev));
      legal = (hp >= 0) && (hr == (hp + 1) % W);
      wrap  = legal && (hp == W - 1);
      if (m_skip) begin
        m_skip = 0;
        m_run  = -1;
      end else if (m_run < 0) begin
        m_run = (hr >= 0) ? 0 : -1;
      end else if (m_run < LOCK) begin
        m_run = legal ? m_run + 1 : -1;
      end else if (legal) begin
        if (wrap) begin
          m_tick = 1;
          m_rev++;
        end
      end else begin
        fcode  = (hr >= 0) ? 2 : 1;
        m_skip = 1;
        m_run  = -1;
      end
      if (hr >= 0) m_phase = hr;
      m_vld  = (hr >= 0);
      m_prev = int'(r);
    end
    if (c) begin
      m_rev = 0; m_err = 0; m_code = 0;
    end
    if (fcode != 0) begin
      if (!m_err) m_code = fcode;
      m_err = 1;
    end
  endtask

  // Drive one sample, let the DUT take it, update the model at the same edge.
  task automatic step(input logic [3:0] r, input logic e, input logic c);
    ring = r; en = e; clr = c;
    @(posedge clk);
    model_step(r, e, c);
    #2;
  endtask

  task automatic rot_step();
    step(cur, 1'b1, 1'b0);
    cur = {cur[2:0], cur[3]};
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("phase", int'(phase), m_phase);
      chk("phase_vld", int'(phase_vld), int'(m_vld));
      chk("locked", int'(locked), int'(m_run >= LOCK));
      chk("rev_tick", int'(rev_tick), int'(m_tick));
      chk("rev_cnt", int'(rev_cnt), m_rev % 256);
      chk("err", int'(err), int'(m_err));
      chk("err_code", int'(err_code), m_code);
      chk("rev_cnt_w2", int'(rev_cnt2), m_rev % 4);
      chk("locked_w2", int'(locked2), int'(m_run >= LOCK));
      chk("err_code_w2", int'(err_code2), m_code);
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; ring = 4'b0000;
    cur = 4'b0001;
    model_reset();
    #12;
    chk("rst_phase", int'(phase), 0);
    chk("rst_vld", int'(phase_vld), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_tick", int'(rev_tick), 0);
    chk("rst_rev", int'(rev_cnt), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_code", int'(err_code), 0);
    rst = 1'b1;
    cmp_on = 1'b1;

    // Clean rotation from reset: lock on 3rd edge, revolutions on edges 5,9,13,17.
    for (int k = 1; k <= 20; k++) begin
      rot_step();
      if (k == 1) begin
        chk("t1_vld", int'(phase_vld), 1);
        chk("t1_locked_e1", int'(locked), 0);
      end
      if (k == 2) chk("t1_locked_e2", int'(locked), 0);
      if (k == 3) chk("t1_locked_e3", int'(locked), 1);
      if (k == 4) chk("t1_tick_e4", int'(rev_tick), 0);
      if (k == 5) begin
        chk("t1_tick_e5", int'(rev_tick), 1);
        chk("t1_rev_e5", int'(rev_cnt), 1);
      end
      if (k == 6) chk("t1_tick_e6", int'(rev_tick), 0);
    end
    chk("t1_rev20", int'(rev_cnt), 4);
    chk("t1_rev20_w2", int'(rev_cnt2), 0);
    chk("t1_err", int'(err), 0);

    // Multi-hot while locked, then clean rotation: fault, discard, anchor, 2 steps.
    step(4'b0011, 1'b1, 1'b0);
    chk("t2_err", int'(err), 1);
    chk("t2_code", int'(err_code), 1);
    chk("t2_locked", int'(locked), 0);
    chk("t2_vld", int'(phase_vld), 0);
    chk("t2_phase_hold", int'(phase), 3);
    rot_step(); rot_step(); rot_step();
    chk("t2_locked_3", int'(locked), 0);
    rot_step();
    chk("t2_relock", int'(locked), 1);
    chk("t2_err_sticky", int'(err), 1);

    // Wrap, clear on a plain step, then a skip fault and a later zero-hot fault.
    rot_step();
    chk("t3_rev5", int'(rev_cnt), 5);
    step(4'b0010, 1'b1, 1'b1);
    chk("t3_clr_err", int'(err), 0);
    chk("t3_clr_rev", int'(rev_cnt), 0);
    step(4'b1000, 1'b1, 1'b0);
    chk("t3_skip_code", int'(err_code), 2);
    chk("t3_skip_locked", int'(locked), 0);
    cur = 4'b0001;
    repeat (4) rot_step();
    chk("t3_relock", int'(locked), 1);
    step(4'b0000, 1'b1, 1'b0);
    chk("t3_first_cause", int'(err_code), 2);
    chk("t3_err", int'(err), 1);
    cur = 4'b0001;
    repeat (4) rot_step();

    // clr coincident with a wrap: clr wins.
    step(4'b0001, 1'b1, 1'b1);
    chk("t5_clr_wrap", int'(rev_cnt), 0);
    chk("t5_clr_wrap_w2", int'(rev_cnt2), 0);
    chk("t5_clr_err", int'(err), 0);
    cur = 4'b0010;
    rot_step(); rot_step();

    // Enable low with the ring frozen: nothing moves.
    for (int k = 0; k < 3; k++) begin
      step(4'b0100, 1'b0, 1'b0);
      chk("t4_tick", int'(rev_tick), 0);
      chk("t4_locked", int'(locked), 1);
      chk("t4_err", int'(err), 0);
      chk("t4_rev", int'(rev_cnt), 0);
    end
    step(4'b1000, 1'b1, 1'b0);
    chk("t4_resume_locked", int'(locked), 1);
    chk("t4_resume_err", int'(err), 0);
    step(4'b0001, 1'b1, 1'b0);
    chk("t4_tick_after", int'(rev_tick), 1);
    chk("t4_rev1", int'(rev_cnt), 1);

    // Narrow counter wraps 2,3,0,1 over four more revolutions.
    cur = 4'b0010;
    for (int r = 0; r < 4; r++) begin
      repeat (4) rot_step();
      chk("t5_rev_w2", int'(rev_cnt2), (2 + r) % 4);
    end
    chk("t5_rev_w8", int'(rev_cnt), 5);

    // clr coincident with a fault while err already holds code 01.
    step(4'b0000, 1'b1, 1'b0);
    chk("t5_zero_code", int'(err_code), 1);
    cur = 4'b0001;
    repeat (4) rot_step();
    chk("t5_relock", int'(locked), 1);
    step(4'b0010, 1'b1, 1'b1);
    chk("t5_clr_fault_err", int'(err), 1);
    chk("t5_clr_fault_code", int'(err_code), 2);
    chk("t5_clr_fault_rev", int'(rev_cnt), 0);

    // Relock, then an asynchronous reset pulse in mid-cycle.
    cur = 4'b0100;
    repeat (4) rot_step();
    chk("t6_locked_pre", int'(locked), 1);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_async_locked", int'(locked), 0);
    chk("t6_async_vld", int'(phase_vld), 0);
    chk("t6_async_phase", int'(phase), 0);
    chk("t6_async_err", int'(err), 0);
    chk("t6_async_code", int'(err_code), 0);
    chk("t6_async_rev", int'(rev_cnt), 0);
    #3;
    rst = 1'b1;
    rot_step();
    rot_step();
    chk("t6_locked_e2", int'(locked), 0);
    rot_step();
    chk("t6_locked_e3", int'(locked), 1);
    chk("t6_rev", int'(rev_cnt), 0);

    ring = cur; en = 1'b0; clr = 1'b0;
    #10;
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
